// File: rtl/npc_pkg.sv
// Shared types and constants for the instruction fetch front end.
package npc_pkg;

  localparam int unsigned XLEN             = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [31:0] INST_NOP         = 32'h0000_0013;

  typedef enum logic [1:0] {
    StReq,
    StWait,
    StHold,
    StDrop
  } fetch_state_e;

endpackage

// File: rtl/ifu_pc.sv
// Program counter: +4 sequential advance, word-aligned redirect with priority.
module ifu_pc import npc_pkg::*; #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_advance,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic [XLEN-1:0] o_pc
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_next;
  logic            w_unused;

  // Target low bits are dropped so the PC stays word aligned.
  assign w_unused = ^i_redirect_pc[1:0];

  always_comb begin
    w_pc_next = r_pc;
    if (i_redirect) begin
      w_pc_next = {i_redirect_pc[XLEN-1:2], 2'b00};
    end else if (i_advance) begin
      w_pc_next = r_pc + XLEN'(4);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one outstanding imem request, valid/ready to decode,
// redirects kill the wrong-path fetch in flight.
module ifu_fetch import npc_pkg::*; #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            imem_rsp_err,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_err,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  fetch_state_e    r_state;
  fetch_state_e    w_state_next;
  logic [XLEN-1:0] w_pc;
  logic [XLEN-1:0] r_inst;
  logic [XLEN-1:0] r_inst_pc;
  logic            r_inst_err;
  logic            w_req_fire;
  logic            w_rsp_take;
  logic            w_consume;

  assign w_req_fire = (r_state == StReq) && imem_req_ready;
  assign w_rsp_take = (r_state == StWait) && imem_rsp_valid && !redirect_valid;
  // A redirect wins over a same-cycle decode handshake.
  assign w_consume  = (r_state == StHold) && inst_ready && !redirect_valid;

  ifu_pc #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_advance     (w_consume),
    .i_redirect    (redirect_valid),
    .i_redirect_pc (redirect_pc),
    .o_pc          (w_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StReq;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StReq: begin
        if (redirect_valid) begin
          w_state_next = w_req_fire ? StDrop : StReq;
        end else if (w_req_fire) begin
          w_state_next = StWait;
        end
      end
      StWait: begin
        if (imem_rsp_valid) begin
          w_state_next = redirect_valid ? StReq : StHold;
        end else if (redirect_valid) begin
          w_state_next = StDrop;
        end
      end
      StHold: begin
        if (redirect_valid || inst_ready) begin
          w_state_next = StReq;
        end
      end
      StDrop: begin
        if (imem_rsp_valid) begin
          w_state_next = StReq;
        end
      end
      default: w_state_next = StReq;
    endcase
  end

  always_comb begin
    imem_req_valid = rst_n && (r_state == StReq);
    inst_valid     = (r_state == StHold);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inst     <= '0;
      r_inst_pc  <= '0;
      r_inst_err <= 1'b0;
    end else if (redirect_valid) begin
      r_inst_err <= 1'b0;
    end else if (w_rsp_take) begin
      r_inst     <= imem_rsp_err ? '0 : imem_rsp_data;
      r_inst_pc  <= w_pc;
      r_inst_err <= imem_rsp_err;
    end else if (w_consume) begin
      r_inst_err <= 1'b0;
    end
  end

  assign imem_req_addr = {w_pc[XLEN-1:2], 2'b00};
  assign inst          = r_inst;
  assign inst_pc       = r_inst_pc;
  assign inst_err      = r_inst_err;

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed vector table, hand-written corner sequences and a
// randomized run against an architectural next-PC model with an address-keyed memory.
module tb_ifu_fetch;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_err;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int unsigned n_tests;
  int unsigned n_fail;

  ifu_fetch #(
    .XLEN     (32),
    .RESET_PC (32'h8000_0000)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_err       (inst_err),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rr;
    logic        rv;
    logic [31:0] d;
    logic        e;
    logic        ir;
    logic        rd;
    logic [31:0] rpc;
    logic        rq;
    logic [31:0] addr;
    logic        iv;
    logic [31:0] inst;
    logic [31:0] ipc;
    logic        ie;
  } vec_t;

  vec_t vecs[$];

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic add(input logic rr, input logic rv, input logic [31:0] d, input logic e,
                     input logic ir, input logic rd, input logic [31:0] rpc,
                     input logic rq, input logic [31:0] addr, input logic iv,
                     input logic [31:0] ins, input logic [31:0] ipc, input logic ie);
    vec_t v;
    v.rr = rr; v.rv = rv; v.d = d; v.e = e; v.ir = ir; v.rd = rd; v.rpc = rpc;
    v.rq = rq; v.addr = addr; v.iv = iv; v.inst = ins; v.ipc = ipc; v.ie = ie;
    vecs.push_back(v);
  endtask

  task automatic drv(input logic rr, input logic rv, input logic [31:0] d, input logic e,
                     input logic ir, input logic rd, input logic [31:0] rpc);
    imem_req_ready = rr;
    imem_rsp_valid = rv;
    imem_rsp_data  = d;
    imem_rsp_err   = e;
    inst_ready     = ir;
    redirect_valid = rd;
    redirect_pc    = rpc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset held across two edges, released mid-cycle away from the edge.
  task automatic do_reset();
    drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    rst_n = 1'b0;
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic errf(input logic [31:0] a);
    return a[6:2] == 5'h0B;
  endfunction

  // Random-phase model state
  logic [31:0] model_pc;
  logic        outstanding;
  logic [31:0] out_addr;
  int unsigned delay;
  int unsigned consumed;
  int unsigned idle;
  logic        prev_stall;
  logic        prev_redirect;
  logic [31:0] prev_inst;
  logic [31:0] prev_ipc;
  logic        prev_err;
  logic        hs;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    rst_n = 1'b0;

    // rr rv d e ir rd rpc | rq addr iv inst ipc ie
    add(1, 0, 32'h0,         0, 0, 0, 32'h0,         1, 32'h8000_0000, 0, 32'h0, 32'h0, 0);
    add(0, 1, 32'h1111_1111, 0, 0, 0, 32'h0,         0, 32'h0, 0, 32'h0, 32'h0, 0);
    add(0, 0, 32'h0,         0, 1, 0, 32'h0,         0, 32'h0, 1, 32'h1111_1111, 32'h8000_0000, 0);
    add(1, 0, 32'h0,         0, 0, 0, 32'h0,         1, 32'h8000_0004, 0, 32'h0, 32'h0, 0);
    add(0, 1, 32'h2222_2222, 0, 0, 0, 32'h0,         0, 32'h0, 0, 32'h0, 32'h0, 0);
    add(0, 0, 32'h0,         0, 1, 0, 32'h0,         0, 32'h0, 1, 32'h2222_2222, 32'h8000_0004, 0);
    add(0, 0, 32'h0,         0, 0, 0, 32'h0,         1, 32'h8000_0008, 0, 32'h0, 32'h0, 0);
    add(1, 0, 32'h0,         0, 0, 0, 32'h0,         1, 32'h8000_0008, 0, 32'h0, 32'h0, 0);
    add(0, 0, 32'h0,         0, 0, 0, 32'h0,         0, 32'h0, 0, 32'h0, 32'h0, 0);
    add(0, 1, 32'h1234_5678, 1, 0, 0, 32'h0,         0, 32'h0, 0, 32'h0, 32'h0, 0);
    add(0, 0, 32'h0,         0, 0, 0, 32'h0,         0, 32'h0, 1, 32'h0, 32'h8000_0008, 1);
    add(0, 0, 32'h0,         0, 1, 0, 32'h0,         0, 32'h0, 1, 32'h0, 32'h8000_0008, 1);
    add(1, 0, 32'h0,         0, 0, 0, 32'h0,         1, 32'h8000_000C, 0, 32'h0, 32'h0, 0);
    add(0, 0, 32'h0,         0, 0, 1, 32'h8000_0100, 0, 32'h0, 0, 32'h0, 32'h0, 0);
    add(0, 0, 32'h0,         0, 0, 0, 32'h0,         0, 32'h0, 0, 32'h0, 32'h0, 0);
    add(0, 0, 32'h0,         0, 0, 0, 32'h0,         0, 32'h0, 0, 32'h0, 32'h0, 0);
    add(0, 1, 32'hDEAD_BEEF, 0, 0, 0, 32'h0,         0, 32'h0, 0, 32'h0, 32'h0, 0);
    add(1, 0, 32'h0,         0, 0, 0, 32'h0,         1, 32'h8000_0100, 0, 32'h0, 32'h0, 0);
    add(0, 1, 32'h3333_3333, 0, 0, 0, 32'h0,         0, 32'h0, 0, 32'h0, 32'h0, 0);
    add(0, 0, 32'h0,         0, 1, 1, 32'h8000_0203, 0, 32'h0, 1, 32'h3333_3333, 32'h8000_0100, 0);
    add(0, 0, 32'h0,         0, 0, 1, 32'hFFFF_FFFF, 1, 32'h8000_0200, 0, 32'h0, 32'h0, 0);
    add(1, 0, 32'h0,         0, 0, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 32'h0, 32'h0, 0);
    add(0, 1, 32'h4444_4444, 0, 0, 0, 32'h0,         0, 32'h0, 0, 32'h0, 32'h0, 0);
    add(0, 0, 32'h0,         0, 1, 0, 32'h0,         0, 32'h0, 1, 32'h4444_4444, 32'hFFFF_FFFC, 0);
    add(1, 0, 32'h0,         0, 0, 1, 32'h8000_0040, 1, 32'h0000_0000, 0, 32'h0, 32'h0, 0);
    add(0, 1, 32'h5555_5555, 0, 0, 1, 32'h8000_0080, 0, 32'h0, 0, 32'h0, 32'h0, 0);
    add(1, 0, 32'h0,         0, 0, 0, 32'h0,         1, 32'h8000_0080, 0, 32'h0, 32'h0, 0);
    add(0, 1, 32'h6666_6666, 0, 0, 1, 32'h8000_0010, 0, 32'h0, 0, 32'h0, 32'h0, 0);
    add(1, 0, 32'h0,         0, 0, 0, 32'h0,         1, 32'h8000_0010, 0, 32'h0, 32'h0, 0);
    add(0, 1, 32'h7777_7777, 0, 0, 0, 32'h0,         0, 32'h0, 0, 32'h0, 32'h0, 0);
    add(0, 0, 32'h0,         0, 1, 0, 32'h0,         0, 32'h0, 1, 32'h7777_7777, 32'h8000_0010, 0);
    add(0, 0, 32'h0,         0, 0, 0, 32'h0,         1, 32'h8000_0014, 0, 32'h0, 32'h0, 0);

    // Reset values while rst_n is low
    tick();
    @(negedge clk);
    chk1("rst_req_valid", imem_req_valid, 1'b0);
    chk1("rst_inst_valid", inst_valid, 1'b0);
    chk32("rst_inst", inst, 32'h0);
    chk32("rst_inst_pc", inst_pc, 32'h0);
    chk1("rst_inst_err", inst_err, 1'b0);
    do_reset();

    foreach (vecs[i]) begin
      drv(vecs[i].rr, vecs[i].rv, vecs[i].d, vecs[i].e, vecs[i].ir, vecs[i].rd, vecs[i].rpc);
      @(negedge clk);
      chk1($sformatf("vec%0d_req_valid", i), imem_req_valid, vecs[i].rq);
      if (vecs[i].rq) chk32($sformatf("vec%0d_addr", i), imem_req_addr, vecs[i].addr);
      chk1($sformatf("vec%0d_inst_valid", i), inst_valid, vecs[i].iv);
      if (vecs[i].iv) begin
        chk32($sformatf("vec%0d_inst", i), inst, vecs[i].inst);
        chk32($sformatf("vec%0d_inst_pc", i), inst_pc, vecs[i].ipc);
        chk1($sformatf("vec%0d_inst_err", i), inst_err, vecs[i].ie);
      end
      tick();
    end

    // Decode stalls five cycles in HOLD: outputs frozen, no new request
    drv(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    drv(1'b0, 1'b1, 32'hABCD_0001, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    for (int k = 0; k < 5; k++) begin
      drv(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      chk1("stall_valid", inst_valid, 1'b1);
      chk32("stall_inst", inst, 32'hABCD_0001);
      chk32("stall_pc", inst_pc, 32'h8000_0014);
      chk1("stall_no_req", imem_req_valid, 1'b0);
      tick();
    end
    drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    tick();
    drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk1("after_stall_req", imem_req_valid, 1'b1);
    chk32("after_stall_addr", imem_req_addr, 32'h8000_0018);
    chk1("after_stall_valid", inst_valid, 1'b0);
    tick();

    // Reset asserted mid-WAIT takes effect without waiting for a clock edge
    drv(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk1("midrst_req_valid", imem_req_valid, 1'b0);
    chk1("midrst_inst_valid", inst_valid, 1'b0);
    chk32("midrst_inst_pc", inst_pc, 32'h0);
    chk1("midrst_inst_err", inst_err, 1'b0);
    do_reset();
    @(negedge clk);
    chk1("postrst_req_valid", imem_req_valid, 1'b1);
    chk32("postrst_addr", imem_req_addr, 32'h8000_0000);
    tick();

    // Randomized run against the architectural model
    do_reset();
    model_pc      = 32'h8000_0000;
    outstanding   = 1'b0;
    out_addr      = 32'h0;
    delay         = 0;
    consumed      = 0;
    idle          = 0;
    prev_stall    = 1'b0;
    prev_redirect = 1'b0;
    prev_inst     = 32'h0;
    prev_ipc      = 32'h0;
    prev_err      = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      imem_req_ready = ($urandom_range(3) != 0);
      imem_rsp_valid = outstanding && (delay == 0);
      imem_rsp_data  = outstanding ? memf(out_addr) : $urandom;
      imem_rsp_err   = outstanding ? errf(out_addr) : 1'b0;
      inst_ready     = ($urandom_range(9) < 7);
      redirect_valid = ($urandom_range(15) == 0);
      redirect_pc    = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(15)) : $urandom;
      @(negedge clk);

      if (prev_stall) begin
        chk1("rnd_hold_valid", inst_valid, 1'b1);
        chk32("rnd_hold_inst", inst, prev_inst);
        chk32("rnd_hold_pc", inst_pc, prev_ipc);
        chk1("rnd_hold_err", inst_err, prev_err);
      end
      if (prev_redirect) chk1("rnd_redirect_kill", inst_valid, 1'b0);
      if (outstanding) chk1("rnd_one_outstanding", imem_req_valid, 1'b0);
      if (imem_rsp_valid) chk1("rnd_rsp_state", imem_req_valid | inst_valid, 1'b0);
      if (imem_req_valid && imem_req_ready) chk32("rnd_req_addr", imem_req_addr, model_pc);
      if (inst_valid) begin
        chk32("rnd_inst_pc", inst_pc, model_pc);
        chk32("rnd_inst", inst, errf(model_pc) ? 32'h0 : memf(model_pc));
        chk1("rnd_inst_err", inst_err, errf(model_pc));
      end

      hs            = inst_valid && inst_ready && !redirect_valid;
      prev_stall    = inst_valid && !inst_ready && !redirect_valid;
      prev_redirect = redirect_valid;
      prev_inst     = inst;
      prev_ipc      = inst_pc;
      prev_err      = inst_err;
      if (redirect_valid) begin
        model_pc = {redirect_pc[31:2], 2'b00};
      end else if (hs) begin
        model_pc = model_pc + 32'd4;
        consumed++;
      end
      if (imem_rsp_valid) begin
        outstanding = 1'b0;
      end else if (outstanding && delay > 0) begin
        delay--;
      end
      if (imem_req_valid && imem_req_ready) begin
        outstanding = 1'b1;
        out_addr    = imem_req_addr;
        delay       = $urandom_range(3);
      end
      idle = (hs || redirect_valid) ? 0 : idle + 1;
      if (idle > 60) begin
        n_tests++;
        n_fail++;
        $display("FAIL rnd_watchdog: no progress for %0d cycles at pc %h", idle, model_pc);
        break;
      end
      tick();
    end
    chk1("rnd_consumed_min", consumed >= 200, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch unit: the producer end of the instruction interface that the decode stage consumes.
- Owns the PC and issues one word-aligned fetch request at a time to the instruction memory port.
- Presents the returned 32-bit instruction and its PC to decode over a valid/ready handshake.
- Accepts redirects (branch/jump/trap target) from the execute stage and discards in-flight wrong-path fetches.

Parameters:
RESET_PC, 32'h8000_0000, PC value loaded on reset; first fetch address
XLEN, 32, address and instruction width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request this cycle
imem_req_addr  out  XLEN  fetch address, bits [1:0] always 0
imem_rsp_valid  in  1  response valid, exactly one per accepted request, at least 1 cycle after acceptance
imem_rsp_data  in  XLEN  fetched instruction word
imem_rsp_err  in  1  access fault for this response
inst_valid  out  1  instruction available to decode
inst_ready  in  1  decode consumes instruction this cycle
inst  out  XLEN  instruction word to decode
inst_pc  out  XLEN  PC of inst
inst_err  out  1  instruction fetch access fault; inst forced to 0
redirect_valid  in  1  redirect PC, single-cycle pulse
redirect_pc  in  XLEN  redirect target; bits [1:0] ignored

Behaviour:
- Reset (async assert, sync deassert handled upstream): pc=RESET_PC, state=REQ. Outputs: imem_req_valid=0 while rst_n low, inst_valid=0, inst=0, inst_pc=0, inst_err=0.
- imem_req_valid = (state==REQ) registered-state decode; imem_req_addr = {pc[31:2],2'b00}.
- States:
  - REQ: request asserted. On imem_req_valid&&imem_req_ready -> WAIT.
  - WAIT: on imem_rsp_valid: latch inst=rsp_err?0:rsp_data, inst_pc=pc, inst_err=rsp_err -> HOLD.
  - HOLD: inst_valid=1. Outputs held stable until inst_ready. On handshake: pc<=pc+4, inst_valid=0 next cycle, -> REQ.
  - DROP: waiting for response of a killed request. On imem_rsp_valid: discard -> REQ.
- Best-case latency: request accepted cycle N, response N+1, inst_valid N+2, next request N+3 if inst_ready at N+2.
- Redirect (highest priority, any state): pc<={redirect_pc[31:2],2'b00}; inst_valid, inst_err cleared next cycle.
  - REQ, no handshake this cycle: -> REQ. Address changes to new pc next cycle; the memory protocol permits address change before acceptance.
  - REQ with handshake same cycle: -> DROP.
  - WAIT without rsp_valid: -> DROP. WAIT with rsp_valid same cycle: response discarded -> REQ.
  - DROP: stay DROP, or -> REQ if rsp_valid this cycle. pc still updated.
  - HOLD: instruction discarded even if inst_ready is high the same cycle (no handshake counted) -> REQ.
- PC arithmetic modulo 2^32: 32'hFFFF_FFFC + 4 = 0.
- Never more than one outstanding request. imem_rsp_valid in REQ/HOLD is a protocol violation: ignored, and asserted against in the bench.
- Fetch fault does not stop fetching; decode/trap logic consumes inst_err and issues the redirect.

Decomposition:
- Shared package npc_pkg: RESET_PC_DEFAULT, XLEN, fetch state enum (REQ, WAIT, HOLD, DROP), INST_NOP=32'h0000_0013 for later use.
- One sub-module is natural: ifu_pc. Holds the PC register, +4 adder, redirect mux and alignment masking; inputs are advance and redirect.
- The FSM and instruction holding register live in ifu_fetch.

Test Plan:
- Reset release, memory always ready, 1-cycle response, inst_ready=1 -> addresses 8000_0000, 8000_0004, 8000_0008; one inst every 3 cycles with matching inst_pc.
- Hold inst_ready=0 for 5 cycles in HOLD -> inst/inst_pc/inst_valid stable, no new imem_req_valid; after ready, next addr = pc+4.
- Redirect to 8000_0100 while in WAIT, response arrives 3 cycles later with data DEADBEEF -> DEADBEEF never presented; next request addr 8000_0100.
- Redirect to 8000_0203 in HOLD with inst_ready=1 same cycle -> instruction not consumed; next addr 8000_0200.
- imem_rsp_err=1 with data 1234_5678 -> inst=0, inst_err=1, inst_pc correct; after handshake next addr = pc+4 with inst_err=0.
- pc forced to FFFF_FFFC via redirect -> after handshake next imem_req_addr = 0000_0000; rst_n pulsed low mid-WAIT -> outputs reset immediately, first request to RESET_PC, stale response ignored by the bench memory model.
